// File: rtl/rr_multiplexer_if.sv
// Four producer channels plus one tagged output stream for rr_multiplexer.
// The multiplexer uses the slave view; producers and the downstream consumer use master.
interface rr_multiplexer_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] W, X, Y, Z;
  logic             W_VALID, X_VALID, Y_VALID, Z_VALID;
  logic             W_READY, X_READY, Y_READY, Z_READY;
  logic [WIDTH-1:0] A;
  logic [1:0]       SEL;
  logic             VALID;
  logic             READY;

  modport master (
    output W, X, Y, Z, W_VALID, X_VALID, Y_VALID, Z_VALID, READY,
    input  W_READY, X_READY, Y_READY, Z_READY, A, SEL, VALID
  );

  modport slave (
    input  W, X, Y, Z, W_VALID, X_VALID, Y_VALID, Z_VALID, READY,
    output W_READY, X_READY, Y_READY, Z_READY, A, SEL, VALID
  );
endinterface

// File: rtl/rr_multiplexer.sv
// Four-channel round-robin multiplexer: one word per cycle from W/X/Y/Z into a
// registered output stream tagged with its source channel index.
module rr_multiplexer #(
  parameter int WIDTH = 2
) (
  input  logic         CLK,
  input  logic         RST_N,
  rr_multiplexer_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;

  logic [WIDTH-1:0] chan_data [4];
  logic [3:0]       chan_valid;
  logic [3:0]       chan_ready;
  logic             load;
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic             handshake;

  assign chan_data[0] = bus.W;
  assign chan_data[1] = bus.X;
  assign chan_data[2] = bus.Y;
  assign chan_data[3] = bus.Z;
  assign chan_valid   = {bus.Z_VALID, bus.Y_VALID, bus.X_VALID, bus.W_VALID};

  // Gated by RST_N so no producer sees READY while reset is held.
  assign load = RST_N && ((state_q == EMPTY) || bus.READY);

  always_comb begin
    logic [1:0] idx;
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    idx         = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!grant_found && chan_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  assign handshake = load && grant_found;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= EMPTY;
      a_q     <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (handshake) begin
      state_d = FULL;
      a_d     = chan_data[grant_idx];
      sel_d   = grant_idx;
      ptr_d   = grant_idx + 2'd1;
    end else if (state_q == FULL && bus.READY) begin
      state_d = EMPTY;
    end
  end

  // Output logic
  for (genvar gi = 0; gi < 4; gi++) begin : g_ready
    assign chan_ready[gi] = handshake && (grant_idx == 2'(gi));
  end

  always_comb begin
    bus.VALID   = (state_q == FULL);
    bus.A       = a_q;
    bus.SEL     = sel_q;
    bus.W_READY = chan_ready[0];
    bus.X_READY = chan_ready[1];
    bus.Y_READY = chan_ready[2];
    bus.Z_READY = chan_ready[3];
  end
endmodule

// File: tb/tb_rr_multiplexer.sv
// Directed bench for rr_multiplexer: a vector table for arbitration/backpressure
// plus hand sequences for single channel, async reset and loopback routing.
module tb_rr_multiplexer;
  logic CLK;
  logic RST_N;
  int   checks;
  int   failures;

  rr_multiplexer_if #(.WIDTH(2)) bus ();

  rr_multiplexer #(.WIDTH(2)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] vld;     // {Z,Y,X,W}
    logic       rdy;
    logic [3:0] exp_cr;  // expected {Z,Y,X,W}_READY before the edge
    logic       exp_v;
    logic [1:0] exp_sel;
    logic [1:0] exp_a;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] cr();
    return {bus.Z_READY, bus.Y_READY, bus.X_READY, bus.W_READY};
  endfunction

  task automatic drive(input logic [3:0] vld, input logic rdy);
    {bus.Z_VALID, bus.Y_VALID, bus.X_VALID, bus.W_VALID} = vld;
    bus.READY = rdy;
  endtask

  task automatic set_data(input logic [1:0] w, input logic [1:0] x, input logic [1:0] y, input logic [1:0] z);
    bus.W = w; bus.X = x; bus.Y = y; bus.Z = z;
  endtask

  // Drive one cycle: check channel readies before the edge, outputs after it.
  task automatic step(input string name, input logic [3:0] vld, input logic rdy,
                      input logic [3:0] exp_cr, input logic exp_v,
                      input logic [1:0] exp_sel, input logic [1:0] exp_a);
    @(negedge CLK);
    drive(vld, rdy);
    #1;
    check({name, ".chan_ready"}, 32'(cr()), 32'(exp_cr));
    @(posedge CLK);
    #1;
    check({name, ".valid"}, 32'(bus.VALID), 32'(exp_v));
    if (exp_v) begin
      check({name, ".sel"}, 32'(bus.SEL), 32'(exp_sel));
      check({name, ".a"}, 32'(bus.A), 32'(exp_a));
    end
    $display("step %s vld=%b rdy=%b cr=%b valid=%b sel=%0d a=%0d",
             name, vld, rdy, cr(), bus.VALID, bus.SEL, bus.A);
  endtask

  initial begin
    logic [1:0] word [4];
    logic [3:0] seen;
    checks   = 0;
    failures = 0;

    // Data is W=0,X=1,Y=2,Z=3 so A must equal SEL throughout the table.
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
    vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
    vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd3};
    vecs[9]  = '{4'b1100, 1'b0, 4'b0100, 1'b1, 2'd2, 2'd2};
    vecs[10] = '{4'b1100, 1'b0, 4'b0000, 1'b1, 2'd2, 2'd2};
    vecs[11] = '{4'b1100, 1'b0, 4'b0000, 1'b1, 2'd2, 2'd2};
    vecs[12] = '{4'b1100, 1'b0, 4'b0000, 1'b1, 2'd2, 2'd2};
    vecs[13] = '{4'b1100, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
    vecs[14] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
    vecs[15] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
    vecs[16] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
    vecs[17] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd0};
    vecs[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0};
    vecs[19] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0};

    RST_N = 1'b0;
    set_data(2'd0, 2'd1, 2'd2, 2'd3);
    drive(4'b1111, 1'b1);
    #2;
    check("reset.chan_ready", 32'(cr()), 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    check("reset.valid", 32'(bus.VALID), 32'h0);
    check("reset.sel", 32'(bus.SEL), 32'h0);
    check("reset.a", 32'(bus.A), 32'h0);
    @(negedge CLK);
    drive(4'b0000, 1'b0);
    RST_N = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step($sformatf("vec%0d", i), vecs[i].vld, vecs[i].rdy, vecs[i].exp_cr,
           vecs[i].exp_v, vecs[i].exp_sel, vecs[i].exp_a);
    end

    // Single channel: X carries 2'b10, distinct from its index.
    set_data(2'd3, 2'b10, 2'd1, 2'd0);
    step("single.grant", 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 2'b10);
    step("single.drain", 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 2'b10);

    // Load Y (pointer becomes 3), then reset mid-cycle while FULL.
    step("prereset.y", 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 2'd1);
    @(negedge CLK);
    drive(4'b1111, 1'b0);
    #1;
    RST_N = 1'b0;
    #1;
    check("midreset.valid", 32'(bus.VALID), 32'h0);
    check("midreset.sel", 32'(bus.SEL), 32'h0);
    check("midreset.a", 32'(bus.A), 32'h0);
    bus.READY = 1'b1;
    #1;
    check("midreset.chan_ready", 32'(cr()), 32'h0);
    @(negedge CLK);
    drive(4'b0000, 1'b0);
    RST_N = 1'b1;
    // Stale pointer 3 would pick Z; a cleared pointer picks W.
    step("postreset.first", 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd3);

    // Loopback: each word must land on the demultiplexer output named by SEL.
    word[0] = 2'b01; word[1] = 2'b10; word[2] = 2'b11; word[3] = 2'b00;
    set_data(word[0], word[1], word[2], word[3]);
    seen = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      drive(4'b1111, 1'b1);
      @(posedge CLK);
      #1;
      check($sformatf("loop%0d.valid", i), 32'(bus.VALID), 32'h1);
      check($sformatf("loop%0d.route", i), 32'(bus.A), 32'(word[bus.SEL]));
      seen[bus.SEL] = 1'b1;
      $display("loop %0d sel=%0d a=%b", i, bus.SEL, bus.A);
    end
    check("loop.all_channels", 32'(seen), 32'hf);

    @(negedge CLK);
    drive(4'b0000, 1'b1);
    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/rr_multiplexer.md
# rr_multiplexer

Four-channel round-robin multiplexer: the transmit-side counterpart of the team's `demultiplexer`. Four independent producer channels W, X, Y, Z each offer a WIDTH-bit word under a valid/ready handshake. The block arbitrates fairly among them and registers one word per cycle onto a single tagged output stream. The tag SEL carries the source channel index, so a downstream `demultiplexer` can route A back to the matching output (SEL 0→W, 1→X, 2→Y, 3→Z).

## Interface
- WIDTH, 2, data width of every channel and of output A.
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- W, X, Y, Z  input  WIDTH each  channel data words, channel indices 0, 1, 2, 3.
- W_VALID, X_VALID, Y_VALID, Z_VALID  input  1 each  channel has a word to send.
- W_READY, X_READY, Y_READY, Z_READY  output  1 each  channel word accepted this cycle (combinational).
- A  output  WIDTH  registered output word.
- SEL  output  2  registered source channel index of A.
- VALID  output  1  A/SEL hold a word not yet taken downstream.
- READY  input  1  downstream accepts A/SEL this cycle.

## Operation
- State machine, derived from the output register state:
  - EMPTY: VALID=0.
  - FULL: VALID=1.
- Load enable: LOAD = !VALID || READY. The output register can take a new word whenever it is empty or is being drained in the same cycle.
- Round-robin pointer PTR (2 bits):
  - The grant is the first asserted channel VALID, scanning PTR, PTR+1, PTR+2, PTR+3 (mod 4).
  - No channel valid → no grant.
- Channel i READY = LOAD && grant==i. At most one channel READY per cycle.
- A channel READY is never asserted for a channel whose VALID is low.
- On a channel handshake (VALID_i && READY_i), at the clock edge:
  - A ← channel i data.
  - SEL ← i.
  - VALID ← 1.
  - PTR ← i+1 (mod 4; 3 wraps to 0).
- On a downstream handshake (VALID && READY) with no new grant: VALID ← 0. A and SEL hold their last values.
- FULL && !READY: A, SEL, VALID and PTR all hold. All channel READY are 0.
- Transitions:
  - EMPTY→FULL on a grant.
  - FULL→FULL on READY with a grant (back-to-back), or on !READY (stall).
  - FULL→EMPTY on READY with no grant.
  - EMPTY→EMPTY with no channel valid.
- Producers hold data stable while VALID_i && !READY_i. The block does not check this.
- Once VALID is high it stays high, with A and SEL stable, until READY.
- Arithmetic: PTR and SEL wrap modulo 4. There is no other arithmetic. Data passes through unmodified at full WIDTH.

## Timing
- Reset (RST_N low, effective immediately, not clock-gated):
  - A=0, SEL=0, VALID=0, PTR=0.
  - All channel READY=0 while reset is held.
- Reset mid-operation: the held word is discarded and VALID drops asynchronously. After release, the first grant starts scanning from channel 0 (W).
- Latency: a channel handshake in cycle n gives VALID=1 with that word on A in cycle n+1.
- Throughput: one word per cycle while READY=1 and any channel is valid.
- Fairness: with all four channels continuously valid and READY=1, the grant sequence is 0,1,2,3,0,… A valid channel waits at most 3 words.
- Simultaneous downstream take and new grant in the same cycle: the new word replaces the old with no bubble. VALID stays 1.
- READY high while EMPTY has no effect beyond enabling LOAD.
- Channel READY depends combinationally on READY, VALID and the channel VALIDs. There is no combinational path from any channel data input to any output.

## Test plan
- Reset: assert RST_N=0 mid-transfer with VALID=1 → A=0, SEL=0, VALID=0 before the next edge. After release, W_VALID=Z_VALID=1 → first SEL=0.
- Single channel: only X_VALID=1, X=2'b10, READY=1 → X_READY=1 in cycle n. A=2'b10, SEL=1, VALID=1 in n+1. VALID=0 in n+2 after X_VALID drops.
- Round-robin: all four VALID=1 with W=0, X=1, Y=2, Z=3, READY=1 for 8 cycles → SEL sequence 0,1,2,3,0,1,2,3 and A equals SEL each cycle. No idle cycles.
- Backpressure: Y_VALID=1, Z_VALID=1, READY=0 for 3 cycles after the first grant → SEL=2 held, A stable, Y_READY and Z_READY both 0. On READY=1 → Z granted the same cycle, SEL=3 next cycle.
- Pointer wrap and skip: after a Z grant, only X_VALID=1 → X granted (SEL=1), then PTR=2. Next, W_VALID and Y_VALID both asserted → Y granted before W.
- Loopback: connect A/SEL to a `demultiplexer`, sending W=01, X=10, Y=11, Z=00 → each value appears only on its matching demultiplexer output when VALID=1.
